// File: rtl/gear_loop_filter.sv
// Purpose : gear-shifted PI loop filter turning phase error into a signed DCO control code.
// Latency : sample accepted on edge N, dco_cc_o/sat_o update with a one-cycle dco_cc_valid_o at edge N+1.
// Backpr. : none; a sample can be taken every cycle, freeze_i simply refuses new samples.
//
// Ports:
//   gen_clk_i, reset_i (async, active-high)
//   error_valid_i/error_i : signed phase-error sample, dropped while freeze_i=1
//   kp_/ki_ acq/trk       : proportional/integral gains for ACQUIRE and for TRACK/LOCKED
//   dco_cc_o/dco_cc_valid_o : clamped control code and its update strobe
//   gear_o (00 ACQ, 01 TRK, 10 LCK), locked_o, sat_o (control code clamped)
module gear_loop_filter #(
    parameter int ERROR_WIDTH   = 8,
    parameter int DCO_CC_WIDTH  = 9,
    parameter int KP_WIDTH      = 4,
    parameter int KP_FRAC_WIDTH = 1,
    parameter int KI_WIDTH      = 6,
    parameter int KI_FRAC_WIDTH = 4,
    parameter int ACC_WIDTH     = 16,
    parameter int LOCK_THRESH   = 2,
    parameter int UNLOCK_THRESH = 8,
    parameter int ACQ_COUNT     = 8,
    parameter int LOCK_COUNT    = 16
) (
    input  logic                    gen_clk_i,
    input  logic                    reset_i,
    input  logic                    error_valid_i,
    input  logic [ERROR_WIDTH-1:0]  error_i,
    input  logic                    freeze_i,
    input  logic [KP_WIDTH-1:0]     kp_acq_i,
    input  logic [KI_WIDTH-1:0]     ki_acq_i,
    input  logic [KP_WIDTH-1:0]     kp_trk_i,
    input  logic [KI_WIDTH-1:0]     ki_trk_i,
    output logic [DCO_CC_WIDTH-1:0] dco_cc_o,
    output logic                    dco_cc_valid_o,
    output logic [1:0]              gear_o,
    output logic                    locked_o,
    output logic                    sat_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Proportional term is realigned to the integrator's fractional grid.
    localparam int SH  = KI_FRAC_WIDTH - KP_FRAC_WIDTH;
    localparam int PW  = ERROR_WIDTH + KP_WIDTH + 1;
    localparam int IW  = ERROR_WIDTH + KI_WIDTH + 1;
    // Working width: wide enough that no intermediate sum can overflow.
    localparam int WW  = max2(max2(PW + SH, ACC_WIDTH), max2(IW, DCO_CC_WIDTH + KI_FRAC_WIDTH)) + 2;
    localparam int CNT_MAX = max2(ACQ_COUNT, LOCK_COUNT);
    localparam int CW  = $clog2(CNT_MAX + 1);

    localparam logic signed [ACC_WIDTH-1:0]    ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0]    ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [DCO_CC_WIDTH-1:0] DCO_MAX = {1'b0, {(DCO_CC_WIDTH-1){1'b1}}};
    localparam logic signed [DCO_CC_WIDTH-1:0] DCO_MIN = {1'b1, {(DCO_CC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        GEAR_ACQ = 2'b00,
        GEAR_TRK = 2'b01,
        GEAR_LCK = 2'b10
    } gear_t;

    gear_t                          gear;
    logic signed [ERROR_WIDTH-1:0]  err_r;
    logic                           s1_vld;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic [CW-1:0]                  cnt;

    logic [KP_WIDTH-1:0]            kp_sel;
    logic [KI_WIDTH-1:0]            ki_sel;
    logic signed [PW-1:0]           err_p, kp_p, p_prod;
    logic signed [IW-1:0]           err_i, ki_i, inc;
    logic signed [WW-1:0]           acc_sum, acc_trunc_w, sum, q, dco_trunc_w;
    logic signed [ACC_WIDTH-1:0]    acc_trunc, acc_sat, acc_next;
    logic signed [DCO_CC_WIDTH-1:0] dco_trunc, dco_next;
    logic                           windup_hold, dco_clamp;
    logic signed [ERROR_WIDTH:0]    err_w;
    logic [ERROR_WIDTH:0]           err_abs;
    logic                           in_band, unlock;
    logic [CW-1:0]                  cnt_inc;

    always_comb begin
        // Gains follow the gear held before this sample's transition.
        kp_sel = (gear == GEAR_ACQ) ? kp_acq_i : kp_trk_i;
        ki_sel = (gear == GEAR_ACQ) ? ki_acq_i : ki_trk_i;

        err_p  = PW'(err_r);
        kp_p   = $signed(PW'(kp_sel));
        p_prod = err_p * kp_p;
        err_i  = IW'(err_r);
        ki_i   = $signed(IW'(ki_sel));
        inc    = err_i * ki_i;

        // Integrator add with saturation instead of wrap.
        acc_sum     = WW'(acc) + WW'(inc);
        acc_trunc   = acc_sum[ACC_WIDTH-1:0];
        acc_trunc_w = WW'(acc_trunc);
        if (acc_sum != acc_trunc_w)
            acc_sat = acc_sum[WW-1] ? ACC_MIN : ACC_MAX;
        else
            acc_sat = acc_trunc;

        // Anti-windup: stop integrating further into an already clamped rail.
        windup_hold = sat_o && (inc != '0) && (inc[IW-1] == dco_cc_o[DCO_CC_WIDTH-1]);
        acc_next    = windup_hold ? acc : acc_sat;

        // Arithmetic shift gives floor division for negative sums.
        sum         = (WW'(p_prod) <<< SH) + WW'(acc_next);
        q           = sum >>> KI_FRAC_WIDTH;
        dco_trunc   = q[DCO_CC_WIDTH-1:0];
        dco_trunc_w = WW'(dco_trunc);
        dco_clamp   = (q != dco_trunc_w);
        if (dco_clamp)
            dco_next = q[WW-1] ? DCO_MIN : DCO_MAX;
        else
            dco_next = dco_trunc;

        // One extra bit so the most negative error has a representable magnitude.
        err_w   = (ERROR_WIDTH+1)'(err_r);
        err_abs = err_r[ERROR_WIDTH-1] ? -err_w : err_w;
        in_band = err_abs <= (ERROR_WIDTH+1)'(LOCK_THRESH);
        unlock  = err_abs >  (ERROR_WIDTH+1)'(UNLOCK_THRESH);
        cnt_inc = (cnt == CW'(CNT_MAX)) ? cnt : cnt + CW'(1);
    end

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_r          <= '0;
            s1_vld         <= 1'b0;
            acc            <= '0;
            cnt            <= '0;
            gear           <= GEAR_ACQ;
            dco_cc_o       <= '0;
            dco_cc_valid_o <= 1'b0;
            sat_o          <= 1'b0;
            locked_o       <= 1'b0;
        end else begin
            s1_vld         <= error_valid_i && !freeze_i;
            dco_cc_valid_o <= s1_vld;
            if (error_valid_i && !freeze_i)
                err_r <= error_i;

            if (s1_vld) begin
                acc      <= acc_next;
                dco_cc_o <= dco_next;
                sat_o    <= dco_clamp;
                cnt      <= in_band ? cnt_inc : '0;
                case (gear)
                    GEAR_ACQ: begin
                        if (in_band && cnt_inc >= CW'(ACQ_COUNT)) begin
                            gear <= GEAR_TRK;
                            cnt  <= '0;
                        end
                    end
                    GEAR_TRK: begin
                        if (in_band && cnt_inc >= CW'(LOCK_COUNT)) begin
                            gear     <= GEAR_LCK;
                            locked_o <= 1'b1;
                        end
                    end
                    GEAR_LCK: begin
                        if (unlock) begin
                            gear     <= GEAR_ACQ;
                            locked_o <= 1'b0;
                            cnt      <= '0;
                        end
                    end
                    default: begin
                        gear     <= GEAR_ACQ;
                        locked_o <= 1'b0;
                        cnt      <= '0;
                    end
                endcase
            end
        end
    end

    assign gear_o = gear;

endmodule

// File: tb/tb_gear_loop_filter.sv
module tb_gear_loop_filter;

    logic       gen_clk_i;
    logic       reset_i;
    logic       error_valid_i;
    logic [7:0] error_i;
    logic       freeze_i;
    logic [3:0] kp_acq_i;
    logic [5:0] ki_acq_i;
    logic [3:0] kp_trk_i;
    logic [5:0] ki_trk_i;
    logic [8:0] dco_cc_o;
    logic       dco_cc_valid_o;
    logic [1:0] gear_o;
    logic       locked_o;
    logic       sat_o;

    int errors = 0;
    int checks = 0;

    gear_loop_filter dut (
        .gen_clk_i      (gen_clk_i),
        .reset_i        (reset_i),
        .error_valid_i  (error_valid_i),
        .error_i        (error_i),
        .freeze_i       (freeze_i),
        .kp_acq_i       (kp_acq_i),
        .ki_acq_i       (ki_acq_i),
        .kp_trk_i       (kp_trk_i),
        .ki_trk_i       (ki_trk_i),
        .dco_cc_o       (dco_cc_o),
        .dco_cc_valid_o (dco_cc_valid_o),
        .gear_o         (gear_o),
        .locked_o       (locked_o),
        .sat_o          (sat_o)
    );

    initial gen_clk_i = 1'b0;
    always #5 gen_clk_i = ~gen_clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int dco, input int sat, input int gear, input int lck);
        chk({tag, "_dco"},    $signed(dco_cc_o), dco);
        chk({tag, "_sat"},    {31'd0, sat_o},    sat);
        chk({tag, "_gear"},   {30'd0, gear_o},   gear);
        chk({tag, "_locked"}, {31'd0, locked_o}, lck);
    endtask

    // One sample: accepted at the next rising edge, strobe must appear one edge later.
    task automatic send(input logic [7:0] e);
        @(negedge gen_clk_i);
        error_valid_i = 1'b1;
        error_i       = e;
        @(negedge gen_clk_i);
        error_valid_i = 1'b0;
        chk("strobe_early", {31'd0, dco_cc_valid_o}, 0);
        @(negedge gen_clk_i);
        chk("strobe", {31'd0, dco_cc_valid_o}, 1);
    endtask

    // Reset pulse between edges; outputs must clear before any edge occurs.
    task automatic do_reset(input string tag);
        @(negedge gen_clk_i);
        #1 reset_i = 1'b1;
        #1;
        chk_out(tag, 0, 0, 0, 0);
        chk({tag, "_strobe"}, {31'd0, dco_cc_valid_o}, 0);
        #1 reset_i = 1'b0;
    endtask

    initial begin
        reset_i       = 1'b1;
        error_valid_i = 1'b0;
        error_i       = '0;
        freeze_i      = 1'b0;
        kp_acq_i      = 4'd4;
        ki_acq_i      = 6'd16;
        kp_trk_i      = 4'd2;
        ki_trk_i      = 6'd8;

        #12;
        chk_out("reset", 0, 0, 0, 0);
        chk("reset_strobe", {31'd0, dco_cc_valid_o}, 0);

        // Basic PI, first sample on the first edge after reset release.
        @(negedge gen_clk_i);
        reset_i       = 1'b0;
        error_valid_i = 1'b1;
        error_i       = 8'd3;
        @(negedge gen_clk_i);
        error_valid_i = 1'b0;
        chk("pi1_strobe_early", {31'd0, dco_cc_valid_o}, 0);
        @(negedge gen_clk_i);
        chk("pi1_strobe", {31'd0, dco_cc_valid_o}, 1);
        chk_out("pi1", 9, 0, 0, 0);
        send(8'd3);
        chk_out("pi2", 12, 0, 0, 0);
        @(negedge gen_clk_i);
        chk("pi_strobe_single", {31'd0, dco_cc_valid_o}, 0);

        // Back-to-back samples of -3.
        error_valid_i = 1'b1;
        error_i       = 8'hFD;
        @(negedge gen_clk_i);
        chk("b2b_strobe0", {31'd0, dco_cc_valid_o}, 0);
        @(negedge gen_clk_i);
        error_valid_i = 1'b0;
        chk("b2b_strobe1", {31'd0, dco_cc_valid_o}, 1);
        chk("b2b_dco1", $signed(dco_cc_o), -3);
        @(negedge gen_clk_i);
        chk("b2b_strobe2", {31'd0, dco_cc_valid_o}, 1);
        chk("b2b_dco2", $signed(dco_cc_o), -6);
        @(negedge gen_clk_i);
        chk("b2b_strobe3", {31'd0, dco_cc_valid_o}, 0);
        chk("b2b_hold", $signed(dco_cc_o), -6);

        // Floor of a negative non-integer sum: -1.5 -> -2.
        kp_acq_i = 4'd1;
        send(8'hFF);
        chk_out("floor", -2, 0, 0, 0);

        // Saturation and anti-windup.
        do_reset("rst_sat");
        kp_acq_i = 4'd15;
        ki_acq_i = 6'd16;
        send(8'd127);
        chk_out("sat1", 255, 1, 0, 0);
        send(8'd127);
        chk_out("sat2", 255, 1, 0, 0);
        send(8'hFF);
        chk_out("sat_release", 118, 0, 0, 0);
        send(8'h80);
        chk_out("sat_neg", -256, 1, 0, 0);

        // Gear sequence.
        do_reset("rst_gear");
        kp_acq_i = 4'd0;
        ki_acq_i = 6'd16;
        kp_trk_i = 4'd0;
        ki_trk_i = 6'd0;
        for (int i = 1; i <= 8; i++) begin
            send(8'd1);
            chk_out($sformatf("acq%0d", i), i, 0, (i == 8) ? 1 : 0, 0);
        end
        for (int i = 1; i <= 16; i++) begin
            send(8'd1);
            chk_out($sformatf("trk%0d", i), 8, 0, (i == 16) ? 2 : 1, (i == 16) ? 1 : 0);
        end
        send(8'd8);
        chk_out("lck_err8", 8, 0, 2, 1);
        send(8'd9);
        chk_out("unlock_err9", 8, 0, 0, 0);
        send(8'd1);
        chk_out("reacq", 9, 0, 0, 0);

        // Out-of-band sample interrupts the TRACK count.
        do_reset("rst_oob");
        for (int i = 1; i <= 7; i++) send(8'hFE);
        send(8'd1);
        chk_out("oob_trk", -13, 0, 1, 0);
        for (int i = 1; i <= 10; i++) send(8'd1);
        send(8'd3);
        chk_out("oob_after3", -13, 0, 1, 0);
        for (int i = 1; i <= 16; i++) begin
            send(8'd1);
            chk({"oob_gear", $sformatf("%0d", i)}, {30'd0, gear_o}, (i == 16) ? 2 : 1);
        end
        chk("oob_locked", {31'd0, locked_o}, 1);

        // Freeze blocks new samples, outputs hold.
        @(negedge gen_clk_i);
        freeze_i      = 1'b1;
        error_valid_i = 1'b1;
        error_i       = 8'd100;
        for (int i = 0; i < 3; i++) begin
            @(negedge gen_clk_i);
            chk("frz_strobe", {31'd0, dco_cc_valid_o}, 0);
            chk_out("frz", -13, 0, 2, 1);
        end

        // A sample captured before freeze rises still completes.
        freeze_i = 1'b0;
        error_i  = 8'd9;
        @(negedge gen_clk_i);
        freeze_i = 1'b1;
        @(negedge gen_clk_i);
        chk("frz_inflight_strobe", {31'd0, dco_cc_valid_o}, 1);
        chk_out("frz_inflight", -13, 0, 0, 0);
        @(negedge gen_clk_i);
        chk("frz_after_strobe", {31'd0, dco_cc_valid_o}, 0);

        // Asynchronous reset in the middle of a live stream.
        freeze_i      = 1'b0;
        kp_acq_i      = 4'd4;
        ki_acq_i      = 6'd16;
        error_i       = 8'd3;
        @(negedge gen_clk_i);
        @(negedge gen_clk_i);
        chk("stream_strobe", {31'd0, dco_cc_valid_o}, 1);
        do_reset("rst_mid");
        @(negedge gen_clk_i);
        chk("post_rst_strobe_early", {31'd0, dco_cc_valid_o}, 0);
        error_valid_i = 1'b0;
        @(negedge gen_clk_i);
        chk("post_rst_strobe", {31'd0, dco_cc_valid_o}, 1);
        chk_out("post_rst", 9, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
